cdb_writeback_arbiter: RTL
==========================

// Module: cdb_writeback_arbiter
// PURPOSE
//  Multi-source, multi-port writeback stage: collects results from NUM_SRC execution units, buffers them
//  per source, and broadcasts up to NUM_CDB results per cycle on the common data bus (PRF write, RS wakeup,
//  ROB complete). Sits between execute/memory units and PRF/RS/ROB. Results are never dropped: sources
//  see backpressure instead. Source 0 is the memory pipe by convention.
// PARAMETERS
//  NUM_SRC   3   result sources (>=2)
//  NUM_CDB   2   broadcast ports per cycle (1..NUM_SRC)
//  QDEPTH    2   entries per source queue (>=1)
//  XLEN      32  result data width
//  PR_BITS   6   physical register index width
//  ROB_BITS  4   ROB index width
// PORTS
//  clk              in   1                  clock, rising edge
//  rst_n            in   1                  asynchronous reset, active low
//  flush            in   1                  pipeline flush: discard all queued results
//  src_valid        in   [NUM_SRC]          result offered by source i
//  src_ready        out  [NUM_SRC]          queue i can accept
//  src_data         in   [NUM_SRC][XLEN]    result value
//  src_phys         in   [NUM_SRC][PR_BITS] destination physical register
//  src_rob_idx      in   [NUM_SRC][ROB_BITS] ROB entry
//  prf_we           out  [NUM_CDB]          PRF write enable per port
//  prf_waddr        out  [NUM_CDB][PR_BITS] PRF write address
//  prf_wdata        out  [NUM_CDB][XLEN]    PRF write data
//  rs_wakeup_valid  out  [NUM_CDB]          RS wakeup strobe
//  rs_wakeup_phys   out  [NUM_CDB][PR_BITS] tag being woken
//  rob_wb_en        out  [NUM_CDB]          ROB completion strobe
//  rob_wb_idx       out  [NUM_CDB][ROB_BITS] completing ROB entry
//  stall_cnt        out  [NUM_SRC][32]      per-source backpressure cycles (CDB_PERF_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, async): all queues empty, rr_ptr=0, stall_cnt=0; hence all CDB outputs 0, src_ready all 1.
//  - Push: src_valid[i] && src_ready[i] at edge k writes entry into queue i. src_ready[i] = (count_i < QDEPTH),
//    from registered count only; a same-cycle pop does not raise ready.
//  - Latency: entry pushed at edge k is visible on CDB in cycle k+1 at the earliest; popped at edge k+1.
//  - Arbitration (combinational on queue heads): scan sources cyclically starting at rr_ptr; first NUM_CDB
//    non-empty queues are granted, at most one entry per source per cycle; j-th grant in scan order drives
//    CDB port j. Ungranted ports drive all fields 0 and strobes 0.
//  - rr_ptr: if any grant, <= (last granted index + 1) mod NUM_SRC; else unchanged. Guarantees no starvation:
//    any non-empty queue is granted within ceil(NUM_SRC/NUM_CDB) cycles.
//  - Per granted port: rs_wakeup_valid=1, rob_wb_en=1, prf_we = (phys != 0); x0 writes suppressed, but wakeup
//    and ROB completion still fire.
//  - Each granted queue pops exactly one entry at the cycle end; push and pop on same queue same edge: count unchanged.
//  - Queue pointers wrap modulo QDEPTH; QDEPTH need not be a power of two.
//  - flush=1: at the edge all queues become empty; pushes offered that cycle are discarded; CDB outputs in the
//    flush cycle still reflect heads (combinational) but no ROB/RS consumer may act on them -- flush is
//    registered upstream. rr_ptr unchanged by flush.
//  - Reset asserted mid-operation: queued results lost, state as above immediately (async).
// CONFIGURATION
//  CDB_PERF_EN defined: stall_cnt[i] increments each cycle src_valid[i] && !src_ready[i], saturating at
//  32'hFFFF_FFFF; cleared only by reset (not by flush).
//  CDB_PERF_EN undefined: stall_cnt port present, tied to 0, no counter flops.
// STRUCTURE
//  - Package wb_pkg: wb_entry_t struct {data[XLEN], phys[PR_BITS], rob_idx[ROB_BITS]} (parameterised via
//    package localparams matching defaults), function next_rr(idx, NUM_SRC).
//  - Sub-module wb_src_fifo: one per source (generate loop); QDEPTH-entry FIFO of wb_entry_t with
//    push/pop/flush, count, full, empty, head. Arbiter, rr_ptr and perf counters live in top module.
// TESTING
//  1. Reset: rst_n low mid-traffic -> all strobes 0, src_ready=3'b111, stall_cnt=0 same cycle.
//  2. Single push src1 {data=0xDEAD_BEEF, phys=5, rob=3} -> next cycle port0: prf_we=1, waddr=5, wdata=DEADBEEF,
//     wakeup phys 5, rob_wb_idx=3; port1 idle.
//  3. All 3 sources push every cycle, rr_ptr=0 -> cycle1 grants src0,src1 (ports 0,1), cycle2 src2,src0,
//     cycle3 src1,src2; src_ready drops when count hits 2; no result lost or duplicated (scoreboard).
//  4. phys=0 push -> prf_we=0, rs_wakeup_valid=1, rob_wb_en=1 on that port.
//  5. Queues holding 2 entries each, flush=1 with src0 push -> next cycle all strobes 0, src_ready all 1.
//  6. CDB_PERF_EN: hold src2 valid while its queue full 7 cycles -> stall_cnt[2]=7; without macro -> 0.

Source files
------------

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and helpers for the CDB writeback arbiter.
//   DEF_NUM_SRC / DEF_NUM_CDB / DEF_QDEPTH : default geometry of the top level
//   XLEN / PR_BITS / ROB_BITS              : field widths of one writeback result
//   wb_entry_t                             : one buffered result {data, phys, rob_idx}
//   next_rr()                              : cyclic successor of a source index
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int DEF_NUM_SRC = 3;
    localparam int DEF_NUM_CDB = 2;
    localparam int DEF_QDEPTH  = 2;
    localparam int XLEN        = 32;
    localparam int PR_BITS     = 6;
    localparam int ROB_BITS    = 4;

    typedef struct packed {
        logic [XLEN-1:0]     data;
        logic [PR_BITS-1:0]  phys;
        logic [ROB_BITS-1:0] rob_idx;
    } wb_entry_t;

    // Index following idx when scanning num_src sources cyclically.
    function automatic int next_rr(input int idx, input int num_src);
        return (idx + 1 >= num_src) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// ---------------------------------------------------------------------------
// wb_src_fifo
// Per-source result queue of QDEPTH wb_entry_t entries (QDEPTH need not be a
// power of two). Push is ignored when full or during flush; pop is ignored
// when empty. Flush empties the queue at the clock edge.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_push      : write i_entry at the tail
//   i_pop       : drop the head entry
//   i_flush     : discard all entries (wins over push/pop)
//   i_entry     : entry to write
//   o_head      : current head entry (valid when !o_empty)
//   o_count     : number of stored entries
//   o_full      : o_count == QDEPTH
//   o_empty     : o_count == 0
// ---------------------------------------------------------------------------
module wb_src_fifo
    import wb_pkg::*;
#(
    parameter int QDEPTH = DEF_QDEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic                        i_flush,
    input  wb_entry_t                   i_entry,
    output wb_entry_t                   o_head,
    output logic [$clog2(QDEPTH+1)-1:0] o_count,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    wb_entry_t         r_mem [QDEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(QDEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign o_full  = (r_count == CW'(QDEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by r_count,
    // so stale contents are never observed and the RAM stays reset-free.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_entry;
    end

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_writeback_arbiter
// Buffers results from NUM_SRC execution units (one wb_src_fifo each) and
// broadcasts up to NUM_CDB of them per cycle on the common data bus. Grants
// are round-robin from r_rr_ptr; the j-th grant in scan order drives port j.
// Results are never dropped: a full queue deasserts src_ready.
// Optional feature macro: CDB_PERF_EN -- per-source saturating backpressure
// counters on stall_cnt; without it stall_cnt is tied to zero.
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : discard all queued results at the edge
//   src_valid/src_ready   : per-source push handshake
//   src_data/phys/rob_idx : per-source result fields
//   prf_we/waddr/wdata    : PRF write port per CDB lane (x0 writes suppressed)
//   rs_wakeup_valid/phys  : RS wakeup per CDB lane
//   rob_wb_en/idx         : ROB completion per CDB lane
//   stall_cnt             : per-source backpressure cycle counters
// ---------------------------------------------------------------------------
module cdb_writeback_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int NUM_CDB = DEF_NUM_CDB,
    parameter int QDEPTH  = DEF_QDEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic [NUM_SRC-1:0]                 src_valid,
    output logic [NUM_SRC-1:0]                 src_ready,
    input  logic [NUM_SRC-1:0][XLEN-1:0]       src_data,
    input  logic [NUM_SRC-1:0][PR_BITS-1:0]    src_phys,
    input  logic [NUM_SRC-1:0][ROB_BITS-1:0]   src_rob_idx,
    output logic [NUM_CDB-1:0]                 prf_we,
    output logic [NUM_CDB-1:0][PR_BITS-1:0]    prf_waddr,
    output logic [NUM_CDB-1:0][XLEN-1:0]       prf_wdata,
    output logic [NUM_CDB-1:0]                 rs_wakeup_valid,
    output logic [NUM_CDB-1:0][PR_BITS-1:0]    rs_wakeup_phys,
    output logic [NUM_CDB-1:0]                 rob_wb_en,
    output logic [NUM_CDB-1:0][ROB_BITS-1:0]   rob_wb_idx,
    output logic [NUM_SRC-1:0][31:0]           stall_cnt
);

    localparam int RRW = $clog2(NUM_SRC);
    localparam int CW  = $clog2(QDEPTH + 1);

    logic [RRW-1:0]     r_rr_ptr;
    wb_entry_t          w_head  [NUM_SRC];
    logic [CW-1:0]      w_count [NUM_SRC];
    logic [NUM_SRC-1:0] w_full;
    logic [NUM_SRC-1:0] w_empty;
    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_pop;
    logic               w_any_grant;
    logic [RRW-1:0]     w_last_grant;
    int                 w_scan_idx;
    int                 w_n_grant;

    // Ready comes from registered occupancy only; a same-cycle pop does not
    // open a slot, which keeps src_ready off the arbiter's combinational path.
    assign src_ready = ~w_full;
    assign w_push    = src_valid & src_ready;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        wb_src_fifo #(.QDEPTH(QDEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_flush (flush),
            .i_entry ('{data: src_data[g], phys: src_phys[g], rob_idx: src_rob_idx[g]}),
            .o_head  (w_head[g]),
            .o_count (w_count[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
        );
    end

    // Cyclic scan from r_rr_ptr; the first NUM_CDB non-empty queues win and
    // are packed onto ports 0..n-1 in scan order.
    // NOTE: every output of this block gets a default first so no path can
    // leave a value held, which would infer a latch.
    always_comb begin
        w_pop           = '0;
        prf_we          = '0;
        prf_waddr       = '0;
        prf_wdata       = '0;
        rs_wakeup_valid = '0;
        rs_wakeup_phys  = '0;
        rob_wb_en       = '0;
        rob_wb_idx      = '0;
        w_any_grant     = 1'b0;
        w_last_grant    = r_rr_ptr;
        w_n_grant       = 0;
        w_scan_idx      = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_scan_idx = int'(r_rr_ptr) + k;
            if (w_scan_idx >= NUM_SRC) w_scan_idx = w_scan_idx - NUM_SRC;
            if (!w_empty[w_scan_idx] && (w_n_grant < NUM_CDB)) begin
                w_pop[w_scan_idx]          = 1'b1;
                prf_we[w_n_grant]          = (w_head[w_scan_idx].phys != '0);
                prf_waddr[w_n_grant]       = w_head[w_scan_idx].phys;
                prf_wdata[w_n_grant]       = w_head[w_scan_idx].data;
                rs_wakeup_valid[w_n_grant] = 1'b1;
                rs_wakeup_phys[w_n_grant]  = w_head[w_scan_idx].phys;
                rob_wb_en[w_n_grant]       = 1'b1;
                rob_wb_idx[w_n_grant]      = w_head[w_scan_idx].rob_idx;
                w_last_grant               = RRW'(w_scan_idx);
                w_any_grant                = 1'b1;
                w_n_grant                  = w_n_grant + 1;
            end
        end
    end

    // Pointer moves past the last winner, which bounds any queue's wait to
    // ceil(NUM_SRC/NUM_CDB) cycles. A flush cycle leaves it where it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_any_grant && !flush) begin
            r_rr_ptr <= RRW'(next_rr(int'(w_last_grant), NUM_SRC));
        end
    end

`ifdef CDB_PERF_EN
    logic [NUM_SRC-1:0][31:0] r_stall_cnt;

    // Saturating; survives flush so stalls can be profiled across mispredicts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_valid[i] && !src_ready[i] && (r_stall_cnt[i] != 32'hFFFF_FFFF))
                    r_stall_cnt[i] <= r_stall_cnt[i] + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
